// File: rtl/tlp_sink_muxn_if.sv
//----------------------------------------------------------------------------
// tlp_sink_muxn_if
//
// Bundle of the TLP source-port handshake and the downstream beat stream
// used by tlp_sink_muxn.
//
// Signals:
//   p_en        per-port enable mask
//   p_has_data  port holds a complete TLP
//   p_req_data  one-hot grant request back to the selected port
//   p_valid     port presents its TLP buffer on p_data this cycle
//   p_data      flat per-port TLP buffers, port k at k*MAX_BEATS*66,
//               beat b: [63:0] data, [64] last, [65] full
//   tx_data     outgoing beat data
//   tx_keep     outgoing byte enable
//   tx_last     last beat of the TLP
//   tx_valid    outgoing beat valid
//   tx_ready    downstream ready
//
// Modports:
//   master  the multiplexer (drives p_req_data and tx_*)
//   slave   the environment (source ports and the downstream sink)
//----------------------------------------------------------------------------
interface tlp_sink_muxn_if #(
    parameter int NPORTS    = 4,
    parameter int MAX_BEATS = 18
);
    logic [NPORTS-1:0]              p_en;
    logic [NPORTS-1:0]              p_has_data;
    logic [NPORTS-1:0]              p_req_data;
    logic [NPORTS-1:0]              p_valid;
    logic [NPORTS*MAX_BEATS*66-1:0] p_data;

    logic [63:0] tx_data;
    logic [7:0]  tx_keep;
    logic        tx_last;
    logic        tx_valid;
    logic        tx_ready;

    modport master (
        input  p_en, p_has_data, p_valid, p_data, tx_ready,
        output p_req_data, tx_data, tx_keep, tx_last, tx_valid
    );

    modport slave (
        output p_en, p_has_data, p_valid, p_data, tx_ready,
        input  p_req_data, tx_data, tx_keep, tx_last, tx_valid
    );
endinterface

// File: rtl/tlp_sink_muxn.sv
//----------------------------------------------------------------------------
// tlp_sink_muxn
//
// Round-robin multiplexer that pulls complete TLPs from NPORTS source ports
// and streams them out as 64-bit beats.
//
// Flow: IDLE picks the next eligible port after the last one served and
// raises a one-hot request (REQ). When that port answers with p_valid its
// whole buffer is captured into a shift register and sent beat by beat
// (SEND), beat 0 of the register always being the beat on the bus.
// Empty beats, TLPs without a last beat inside MAX_BEATS, and ports that do
// not answer within REQ_TIMEOUT cycles are counted as errors.
//
// Ports:
//   clk        clock, all logic on the rising edge
//   rst        synchronous active-high reset
//   bus        tlp_sink_muxn_if.master (source ports + tx stream)
//   busy       state is not IDLE
//   grant_id   index of the current / most recent grant
//   tlp_count  TLPs sent, saturating
//   err_count  malformed / overlong / timeout events, saturating
//----------------------------------------------------------------------------
module tlp_sink_muxn #(
    parameter int NPORTS      = 4,
    parameter int MAX_BEATS   = 18,
    parameter int REQ_TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    tlp_sink_muxn_if.master     bus,
    output logic                busy,
    output logic [2:0]          grant_id,
    output logic [15:0]         tlp_count,
    output logic [15:0]         err_count
);

    localparam int BEAT_W = 66;
    localparam int BUF_W  = MAX_BEATS * BEAT_W;
    localparam int IDX_W  = $clog2(MAX_BEATS + 1);
    localparam int TMO_W  = $clog2(REQ_TIMEOUT + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_SEND = 2'd2;

    localparam logic [NPORTS-1:0] ONE_HOT_0 = 1;

    logic [1:0]        state;
    logic [2:0]        last_grant;
    logic [BUF_W-1:0]  shift_reg;
    logic [IDX_W-1:0]  beat_idx;
    logic [TMO_W-1:0]  req_timer;

    logic [NPORTS-1:0] eligible;
    logic [NPORTS-1:0] grant_onehot;
    logic [2:0]        pick_idx;
    logic              sel_valid;
    logic [BUF_W-1:0]  sel_buf;

    logic [BEAT_W-1:0] beat0;
    logic              b_last;
    logic              b_full;
    logic              in_send;
    logic              overlong;
    logic              malformed;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    //------------------------------------------------------------------
    // Arbitration: the winner is the eligible port with the smallest
    // forward distance from last_grant, so last_grant itself is served
    // last and every other eligible port gets its turn first.
    //------------------------------------------------------------------
    assign eligible = bus.p_has_data & bus.p_en;

    // NOTE: every variable written in a combinational block gets a default
    // at the top; a path that leaves one unassigned would infer a latch.
    always_comb begin
        int best_dist;
        int d;
        best_dist = NPORTS;
        d         = 0;
        pick_idx  = 3'd0;
        for (int j = 0; j < NPORTS; j++) begin
            if (eligible[j]) begin
                d = j - int'(last_grant) - 1;
                if (d < 0)
                    d = d + NPORTS;
                if (d < best_dist) begin
                    best_dist = d;
                    pick_idx  = 3'(j);
                end
            end
        end
    end

    // Granted port selection; valid and buffers of other ports are ignored.
    assign grant_onehot = ONE_HOT_0 << grant_id;
    assign sel_valid    = |(bus.p_valid & grant_onehot);

    always_comb begin
        sel_buf = '0;
        for (int k = 0; k < NPORTS; k++) begin
            if (grant_id == 3'(k))
                sel_buf = bus.p_data[k*BUF_W +: BUF_W];
        end
    end

    //------------------------------------------------------------------
    // Output decode. Everything is a function of registered state, so
    // tx_valid never depends on tx_ready within the same cycle.
    //------------------------------------------------------------------
    assign beat0     = shift_reg[BEAT_W-1:0];
    assign b_last    = beat0[64];
    assign b_full    = beat0[65];
    assign in_send   = (state == S_SEND);
    assign overlong  = (beat_idx == IDX_W'(MAX_BEATS));
    assign malformed = ~b_last & ~b_full;

    assign bus.tx_valid   = in_send & (b_last | b_full);
    assign bus.tx_last    = in_send & b_last;
    assign bus.tx_data    = in_send ? beat0[63:0] : 64'd0;
    // A short last beat carries only the low DWORD.
    assign bus.tx_keep    = (in_send & b_last & ~b_full) ? 8'h0f : 8'hff;
    assign bus.p_req_data = (state == S_REQ) ? grant_onehot : '0;
    assign busy           = (state != S_IDLE);

    //------------------------------------------------------------------
    // State machine
    //------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values from before this clock edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            // NOTE: the wide TLP shift register is cleared on reset so no
            // stale beat can reach tx_data after a reset in mid-TLP.
            shift_reg  <= '0;
            beat_idx   <= '0;
            req_timer  <= '0;
            last_grant <= 3'(NPORTS - 1);
            grant_id   <= 3'd0;
            tlp_count  <= 16'd0;
            err_count  <= 16'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (|eligible) begin
                        grant_id  <= pick_idx;
                        req_timer <= '0;
                        state     <= S_REQ;
                    end
                end

                S_REQ: begin
                    if (sel_valid) begin
                        shift_reg <= sel_buf;
                        beat_idx  <= '0;
                        state     <= S_SEND;
                    end else if (req_timer == TMO_W'(REQ_TIMEOUT - 1)) begin
                        // Port never answered: abandon the grant and move on.
                        err_count  <= sat_inc(err_count);
                        last_grant <= grant_id;
                        state      <= S_IDLE;
                    end else begin
                        req_timer <= req_timer + TMO_W'(1);
                    end
                end

                S_SEND: begin
                    if (overlong || malformed) begin
                        // Whole buffer consumed without a last beat, or an
                        // empty beat: drop the rest of the TLP.
                        err_count  <= sat_inc(err_count);
                        last_grant <= grant_id;
                        state      <= S_IDLE;
                    end else if (bus.tx_ready) begin
                        shift_reg <= shift_reg >> BEAT_W;
                        beat_idx  <= beat_idx + IDX_W'(1);
                        if (b_last) begin
                            tlp_count  <= sat_inc(tlp_count);
                            last_grant <= grant_id;
                            state      <= S_IDLE;
                        end
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tlp_sink_muxn.sv
//----------------------------------------------------------------------------
// tb_tlp_sink_muxn
//
// Directed self-checking bench for tlp_sink_muxn (NPORTS=4, MAX_BEATS=18,
// REQ_TIMEOUT=255). Inputs are driven and outputs sampled 1 ns after each
// rising edge.
//----------------------------------------------------------------------------
module tb_tlp_sink_muxn;

    localparam int NPORTS    = 4;
    localparam int MAX_BEATS = 18;
    localparam int BUF_W     = MAX_BEATS * 66;

    logic        clk = 1'b0;
    logic        rst;
    logic        busy;
    logic [2:0]  grant_id;
    logic [15:0] tlp_count;
    logic [15:0] err_count;

    tlp_sink_muxn_if #(.NPORTS(NPORTS), .MAX_BEATS(MAX_BEATS)) bus ();

    tlp_sink_muxn #(
        .NPORTS(NPORTS),
        .MAX_BEATS(MAX_BEATS),
        .REQ_TIMEOUT(255)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.master),
        .busy(busy),
        .grant_id(grant_id),
        .tlp_count(tlp_count),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [63:0] cap_data [$];
    logic [7:0]  cap_keep [$];
    logic        cap_last [$];
    int          first_beat_at;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_beat(input int port, input int b, input logic full,
                            input logic last, input logic [63:0] d);
        bus.p_data[port*BUF_W + b*66 +: 66] = {full, last, d};
    endtask

    task automatic clear_buf(input int port);
        bus.p_data[port*BUF_W +: BUF_W] = '0;
    endtask

    // Runs ncyc cycles recording every beat the DUT offers while ready is high.
    task automatic capture(input int ncyc);
        cap_data.delete();
        cap_keep.delete();
        cap_last.delete();
        first_beat_at = -1;
        for (int i = 0; i < ncyc; i++) begin
            tick();
            if (bus.tx_valid && bus.tx_ready) begin
                cap_data.push_back(bus.tx_data);
                cap_keep.push_back(bus.tx_keep);
                cap_last.push_back(bus.tx_last);
                if (first_beat_at < 0)
                    first_beat_at = i;
            end
        end
    endtask

    //------------------------------------------------------------------
    task automatic test_reset();
        rst            = 1'b1;
        bus.p_en       = '0;
        bus.p_has_data = '0;
        bus.p_valid    = '0;
        bus.p_data     = '0;
        bus.tx_ready   = 1'b1;
        tick();
        tick();
        tests_run++; if (bus.tx_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_tx_valid: got %b want 0", bus.tx_valid); end
        tests_run++; if (bus.tx_last !== 1'b0) begin tests_failed++; $display("FAIL reset_tx_last: got %b want 0", bus.tx_last); end
        tests_run++; if (bus.tx_keep !== 8'hff) begin tests_failed++; $display("FAIL reset_tx_keep: got %h want ff", bus.tx_keep); end
        tests_run++; if (bus.tx_data !== 64'd0) begin tests_failed++; $display("FAIL reset_tx_data: got %h want 0", bus.tx_data); end
        tests_run++; if (bus.p_req_data !== 4'b0000) begin tests_failed++; $display("FAIL reset_p_req_data: got %b want 0000", bus.p_req_data); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b want 0", busy); end
        tests_run++; if (grant_id !== 3'd0) begin tests_failed++; $display("FAIL reset_grant_id: got %0d want 0", grant_id); end
        tests_run++; if (tlp_count !== 16'd0) begin tests_failed++; $display("FAIL reset_tlp_count: got %0d want 0", tlp_count); end
        tests_run++; if (err_count !== 16'd0) begin tests_failed++; $display("FAIL reset_err_count: got %0d want 0", err_count); end
        rst = 1'b0;
        tick();
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL idle_no_eligible_busy: got %b want 0", busy); end
    endtask

    //------------------------------------------------------------------
    // Port 1 alone, beats full, full, last&~full.
    task automatic test_single_port();
        logic [63:0] exp_d [3];
        logic [7:0]  exp_k [3];
        logic        exp_l [3];
        exp_d = '{64'h1111_0000_0000_0001, 64'h1111_0000_0000_0002, 64'h1111_0000_0000_0003};
        exp_k = '{8'hff, 8'hff, 8'h0f};
        exp_l = '{1'b0, 1'b0, 1'b1};
        set_beat(1, 0, 1'b1, 1'b0, exp_d[0]);
        set_beat(1, 1, 1'b1, 1'b0, exp_d[1]);
        set_beat(1, 2, 1'b0, 1'b1, exp_d[2]);
        bus.p_en       = 4'b1111;
        bus.p_has_data = 4'b0010;
        bus.p_valid    = 4'b0010;
        tick();
        tests_run++; if (bus.p_req_data !== 4'b0010) begin tests_failed++; $display("FAIL single_req: got %b want 0010", bus.p_req_data); end
        tests_run++; if (grant_id !== 3'd1) begin tests_failed++; $display("FAIL single_grant: got %0d want 1", grant_id); end
        tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL single_busy: got %b want 1", busy); end
        bus.p_has_data = 4'b0000;
        capture(5);
        tests_run++; if (first_beat_at !== 0) begin tests_failed++; $display("FAIL single_latency: first beat at %0d want 0", first_beat_at); end
        tests_run++; if (cap_data.size() !== 3) begin tests_failed++; $display("FAIL single_beats: got %0d want 3", cap_data.size()); end
        for (int i = 0; i < cap_data.size() && i < 3; i++) begin
            tests_run++; if (cap_data[i] !== exp_d[i]) begin tests_failed++; $display("FAIL single_data%0d: got %h want %h", i, cap_data[i], exp_d[i]); end
            tests_run++; if (cap_keep[i] !== exp_k[i]) begin tests_failed++; $display("FAIL single_keep%0d: got %h want %h", i, cap_keep[i], exp_k[i]); end
            tests_run++; if (cap_last[i] !== exp_l[i]) begin tests_failed++; $display("FAIL single_last%0d: got %b want %b", i, cap_last[i], exp_l[i]); end
        end
        tests_run++; if (tlp_count !== 16'd1) begin tests_failed++; $display("FAIL single_tlp_count: got %0d want 1", tlp_count); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL single_idle: busy %b want 0", busy); end
    endtask

    //------------------------------------------------------------------
    // All ports eligible after reset; port 1 disabled during the 5th grant.
    task automatic test_round_robin();
        int   order [8];
        logic found;
        logic [3:0] exp_req;
        order = '{0, 1, 2, 3, 0, 2, 3, 0};
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < NPORTS; k++) begin
            clear_buf(k);
            set_beat(k, 0, 1'b1, 1'b1, 64'hA0 + 64'(k));
        end
        bus.p_en       = 4'b1111;
        bus.p_has_data = 4'b1111;
        bus.p_valid    = 4'b1111;
        for (int n = 0; n < 8; n++) begin
            if (n == 5)
                bus.p_en = 4'b1101;
            found = 1'b0;
            for (int c = 0; c < 8 && !found; c++) begin
                tick();
                if (bus.p_req_data != 4'b0000)
                    found = 1'b1;
            end
            exp_req = 4'(1 << order[n]);
            tests_run++; if (found !== 1'b1) begin tests_failed++; $display("FAIL rr_wait%0d: no request within 8 cycles", n); end
            tests_run++; if (bus.p_req_data !== exp_req) begin tests_failed++; $display("FAIL rr_req%0d: got %b want %b", n, bus.p_req_data, exp_req); end
            tests_run++; if (grant_id !== 3'(order[n])) begin tests_failed++; $display("FAIL rr_grant%0d: got %0d want %0d", n, grant_id, order[n]); end
        end
        bus.p_has_data = 4'b0000;
        bus.p_en       = 4'b1111;
        for (int c = 0; c < 4; c++) tick();
        tests_run++; if (tlp_count !== 16'd8) begin tests_failed++; $display("FAIL rr_tlp_count: got %0d want 8", tlp_count); end
        tests_run++; if (err_count !== 16'd0) begin tests_failed++; $display("FAIL rr_err_count: got %0d want 0", err_count); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL rr_idle: busy %b want 0", busy); end
    endtask

    //------------------------------------------------------------------
    // 4-beat TLP on port 2 with tx_ready pattern 1,0,0,1.
    task automatic test_backpressure();
        logic        pat [4];
        logic [73:0] prev;
        logic [73:0] cur;
        logic        prev_hold;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        clear_buf(2);
        for (int b = 0; b < 4; b++)
            set_beat(2, b, 1'b1, (b == 3), 64'hB0 + 64'(b));
        bus.p_has_data = 4'b0100;
        bus.p_valid    = 4'b0100;
        bus.tx_ready   = 1'b1;
        tick();
        tests_run++; if (grant_id !== 3'd2) begin tests_failed++; $display("FAIL bp_grant: got %0d want 2", grant_id); end
        bus.p_has_data = 4'b0000;
        cap_data.delete();
        prev      = '0;
        prev_hold = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tick();
            cur = {bus.tx_valid, bus.tx_last, bus.tx_keep, bus.tx_data};
            if (prev_hold) begin
                tests_run++; if (cur !== prev) begin tests_failed++; $display("FAIL bp_hold%0d: got %h want %h", i, cur, prev); end
            end
            bus.tx_ready = pat[i % 4];
            if (bus.tx_valid && bus.tx_ready)
                cap_data.push_back(bus.tx_data);
            prev      = cur;
            prev_hold = bus.tx_valid && !bus.tx_ready;
        end
        bus.tx_ready = 1'b1;
        tests_run++; if (cap_data.size() !== 4) begin tests_failed++; $display("FAIL bp_beats: got %0d want 4", cap_data.size()); end
        for (int i = 0; i < cap_data.size() && i < 4; i++) begin
            tests_run++; if (cap_data[i] !== 64'hB0 + 64'(i)) begin tests_failed++; $display("FAIL bp_data%0d: got %h want %h", i, cap_data[i], 64'hB0 + 64'(i)); end
        end
        tests_run++; if (tlp_count !== 16'd9) begin tests_failed++; $display("FAIL bp_tlp_count: got %0d want 9", tlp_count); end
    endtask

    //------------------------------------------------------------------
    // Port 3 granted but silent (only non-granted ports raise p_valid).
    task automatic test_timeout();
        int cnt;
        bus.p_has_data = 4'b1001;
        bus.p_valid    = 4'b0110;
        tick();
        tests_run++; if (grant_id !== 3'd3) begin tests_failed++; $display("FAIL to_grant: got %0d want 3", grant_id); end
        tests_run++; if (bus.p_req_data !== 4'b1000) begin tests_failed++; $display("FAIL to_req: got %b want 1000", bus.p_req_data); end
        cnt = 1;
        for (int c = 0; c < 300; c++) begin
            tick();
            if (bus.p_req_data == 4'b1000)
                cnt++;
            else
                break;
        end
        tests_run++; if (cnt !== 255) begin tests_failed++; $display("FAIL to_req_cycles: got %0d want 255", cnt); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL to_busy: got %b want 0", busy); end
        tests_run++; if (err_count !== 16'd1) begin tests_failed++; $display("FAIL to_err_count: got %0d want 1", err_count); end
        tick();
        tests_run++; if (grant_id !== 3'd0) begin tests_failed++; $display("FAIL to_next_grant: got %0d want 0", grant_id); end
        tests_run++; if (bus.p_req_data !== 4'b0001) begin tests_failed++; $display("FAIL to_next_req: got %b want 0001", bus.p_req_data); end
        bus.p_valid    = 4'b0001;
        bus.p_has_data = 4'b0000;
        for (int c = 0; c < 4; c++) tick();
        tests_run++; if (tlp_count !== 16'd10) begin tests_failed++; $display("FAIL to_tlp_count: got %0d want 10", tlp_count); end
    endtask

    //------------------------------------------------------------------
    // 18 full beats with no last on port 1, then an empty buffer on port 2.
    task automatic test_overlong_empty();
        int nlast;
        clear_buf(1);
        for (int b = 0; b < MAX_BEATS; b++)
            set_beat(1, b, 1'b1, 1'b0, 64'hC00 + 64'(b));
        bus.p_has_data = 4'b0010;
        bus.p_valid    = 4'b0010;
        tick();
        tests_run++; if (grant_id !== 3'd1) begin tests_failed++; $display("FAIL ol_grant: got %0d want 1", grant_id); end
        bus.p_has_data = 4'b0000;
        capture(22);
        nlast = 0;
        foreach (cap_last[i]) if (cap_last[i]) nlast++;
        tests_run++; if (cap_data.size() !== MAX_BEATS) begin tests_failed++; $display("FAIL ol_beats: got %0d want %0d", cap_data.size(), MAX_BEATS); end
        tests_run++; if (nlast !== 0) begin tests_failed++; $display("FAIL ol_last: got %0d last beats want 0", nlast); end
        if (cap_data.size() == MAX_BEATS) begin
            tests_run++; if (cap_data[MAX_BEATS-1] !== 64'hC11) begin tests_failed++; $display("FAIL ol_final_data: got %h want c11", cap_data[MAX_BEATS-1]); end
        end
        tests_run++; if (err_count !== 16'd2) begin tests_failed++; $display("FAIL ol_err_count: got %0d want 2", err_count); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL ol_busy: got %b want 0", busy); end

        clear_buf(2);
        bus.p_has_data = 4'b0100;
        bus.p_valid    = 4'b0100;
        tick();
        tests_run++; if (grant_id !== 3'd2) begin tests_failed++; $display("FAIL empty_grant: got %0d want 2", grant_id); end
        bus.p_has_data = 4'b0000;
        capture(4);
        tests_run++; if (cap_data.size() !== 0) begin tests_failed++; $display("FAIL empty_beats: got %0d want 0", cap_data.size()); end
        tests_run++; if (err_count !== 16'd3) begin tests_failed++; $display("FAIL empty_err_count: got %0d want 3", err_count); end
        tests_run++; if (tlp_count !== 16'd10) begin tests_failed++; $display("FAIL empty_tlp_count: got %0d want 10", tlp_count); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL empty_busy: got %b want 0", busy); end
    endtask

    //------------------------------------------------------------------
    // Reset while beat 2 of a 5-beat TLP on port 3 is on the bus.
    task automatic test_reset_mid_send();
        clear_buf(3);
        for (int b = 0; b < 5; b++)
            set_beat(3, b, 1'b1, (b == 4), 64'hD0 + 64'(b));
        bus.p_has_data = 4'b1000;
        bus.p_valid    = 4'b1111;
        tick();
        tests_run++; if (grant_id !== 3'd3) begin tests_failed++; $display("FAIL rm_grant: got %0d want 3", grant_id); end
        tick();
        tests_run++; if (bus.tx_data !== 64'hD0) begin tests_failed++; $display("FAIL rm_beat0: got %h want d0", bus.tx_data); end
        tick();
        tests_run++; if (bus.tx_data !== 64'hD1 || bus.tx_valid !== 1'b1) begin tests_failed++; $display("FAIL rm_beat1: got %h/%b want d1/1", bus.tx_data, bus.tx_valid); end
        rst            = 1'b1;
        bus.p_has_data = 4'b1111;
        tick();
        tests_run++; if (bus.tx_valid !== 1'b0) begin tests_failed++; $display("FAIL rm_tx_valid: got %b want 0", bus.tx_valid); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL rm_busy: got %b want 0", busy); end
        tests_run++; if (tlp_count !== 16'd0) begin tests_failed++; $display("FAIL rm_tlp_count: got %0d want 0", tlp_count); end
        tests_run++; if (err_count !== 16'd0) begin tests_failed++; $display("FAIL rm_err_count: got %0d want 0", err_count); end
        tests_run++; if (bus.tx_data !== 64'd0) begin tests_failed++; $display("FAIL rm_tx_data: got %h want 0", bus.tx_data); end
        rst = 1'b0;
        tick();
        tests_run++; if (grant_id !== 3'd0) begin tests_failed++; $display("FAIL rm_restart_grant: got %0d want 0", grant_id); end
        tests_run++; if (bus.p_req_data !== 4'b0001) begin tests_failed++; $display("FAIL rm_restart_req: got %b want 0001", bus.p_req_data); end
        bus.p_has_data = 4'b0000;
        for (int c = 0; c < 4; c++) tick();
    endtask

    //------------------------------------------------------------------
    initial begin
        rst            = 1'b1;
        bus.p_en       = '0;
        bus.p_has_data = '0;
        bus.p_valid    = '0;
        bus.p_data     = '0;
        bus.tx_ready   = 1'b1;
        test_reset();
        test_single_port();
        test_round_robin();
        test_backpressure();
        test_timeout();
        test_overlong_empty();
        test_reset_mid_send();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded 200000 ns");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/tlp_sink_muxn.md
TLP_SINK_MUXN -- requirements
Module: tlp_sink_muxn

Interface
REQ-001 Parameter NPORTS, default 4, number of TLP source ports (2..8).
REQ-002 Parameter MAX_BEATS, default 18, max 66-bit beats per TLP buffer.
REQ-003 Parameter REQ_TIMEOUT, default 255, cycles allowed in REQ before abandoning a grant.
REQ-004 clk  in  1  clock; all logic on posedge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 p_en  in  NPORTS  per-port enable mask.
REQ-007 p_has_data  in  NPORTS  port holds a complete TLP.
REQ-008 p_req_data  out  NPORTS  one-hot grant request to port.
REQ-009 p_valid  in  NPORTS  port presents its TLP on p_data this cycle.
REQ-010 p_data  in  NPORTS*MAX_BEATS*66  per-port flat TLP buffers. Port k occupies slice k*MAX_BEATS*66. Beat b: [63:0] data, [64] last, [65] full (both DWORDs valid).
REQ-011 tx_data  out  64  beat data.
REQ-012 tx_keep  out  8  byte enable.
REQ-013 tx_last  out  1  last beat of TLP.
REQ-014 tx_valid  out  1  beat valid.
REQ-015 tx_ready  in  1  downstream ready.
REQ-016 busy  out  1  state != IDLE.
REQ-017 grant_id  out  3  port index of current/last grant.
REQ-018 tlp_count  out  16  TLPs sent; saturating.
REQ-019 err_count  out  16  malformed/overlong/timeout events; saturating.

Function
REQ-020 FSM states IDLE, REQ and SEND, all registered.
REQ-021 IDLE: eligible = p_has_data & p_en.
REQ-022 IDLE, eligible nonzero: round-robin pick of the first eligible index after last_grant (modulo NPORTS), store it in grant_id, go to REQ.
REQ-023 REQ: p_req_data = one-hot(grant_id); p_req_data is 0 in all other states.
REQ-024 REQ, p_valid[grant_id]=1: load the port's buffer into the shift register, set beat index 0, go to SEND. This cycle p_req_data is still asserted.
REQ-025 REQ: p_valid from non-granted ports is ignored.
REQ-026 REQ: REQ_TIMEOUT consecutive cycles without p_valid[grant_id] -> err_count+1, go to IDLE, last_grant=grant_id.
REQ-027 SEND: tx_data = beat0[63:0].
REQ-028 SEND: tx_last = beat0[64].
REQ-029 SEND: tx_keep = 8'h0f when last & ~full, else 8'hff.
REQ-030 SEND: tx_valid = beat0[64] | beat0[65]. tx_valid has no combinational dependency on tx_ready.
REQ-031 SEND, tx_valid & tx_ready: shift the register right 66 bits (zero fill) and increment the beat index.
REQ-032 SEND, tx_valid & tx_ready & tx_last: tlp_count+1, last_grant=grant_id, go to IDLE.
REQ-033 SEND, tx_ready=0: hold all outputs and state stable.
REQ-034 SEND, beat0 with last=0 and full=0 (malformed/empty): tx_valid=0, err_count+1, go to IDLE next cycle.
REQ-035 SEND, beat index = MAX_BEATS without a last beat: err_count+1, go to IDLE.
REQ-036 Changes to p_en and p_has_data affect only IDLE arbitration decisions; a grant in progress is never cancelled.
REQ-037 Minimum latency from eligible in IDLE to the first tx_valid is 3 cycles (IDLE->REQ, valid returned, SEND).
REQ-038 Counters saturate at 16'hFFFF.

Reset
REQ-039 rst has priority over all other events, including mid-SEND. Effect: state=IDLE, shift register=0, last_grant=NPORTS-1, grant_id=0, counters=0.
REQ-040 Reset values of outputs: tx_valid=0, tx_last=0, tx_keep=8'hff, tx_data=0, p_req_data=0, busy=0.

Verification
REQ-041 Port 1 only eligible, 3-beat TLP (beats full, full, last&~full), tx_ready=1 -> 3 tx beats with keep ff, ff, 0f; tx_last on beat 3; tlp_count=1.
REQ-042 All 4 ports eligible continuously after reset -> grant order 0,1,2,3,0; port disabled via p_en mid-sequence is skipped at next IDLE.
REQ-043 tx_ready toggling 1,0,0,1 during SEND -> no beat lost or duplicated; outputs stable while ready=0.
REQ-044 Granted port never asserts p_valid -> p_req_data held 255 cycles, then err_count=1, busy=0, next eligible port granted.
REQ-045 Buffer with 18 full beats and no last -> 18 beats sent, err_count=1, return to IDLE; beat0 empty -> no tx_valid, err_count+1.
REQ-046 rst asserted on beat 2 of a 5-beat TLP -> next cycle tx_valid=0, busy=0, counters=0; the next grant restarts at port 0.
